alu_operand_fetch: RTL and testbench
====================================

// Module: alu_operand_fetch
// PURPOSE
//  Operand-fetch stage directly upstream of the 16-bit combinational ALU.
//  Holds the 8-entry register file, reads two sources, selects an immediate,
//  and presents a registered {inp1, inp2, func, dst} bundle to the ALU over a
//  valid/ready handshake.
//  A pending-write scoreboard stalls issue on read-after-write hazards, and a
//  write-back port with same-cycle bypass accepts ALU results.
// PARAMETERS
//  n      16   datapath width (register, immediate and ALU operand width)
//  NREG    8   register count; register address width is 3 bits, fixed
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   instruction descriptor valid
//  in_ready   out  1   stage can accept the descriptor (combinational)
//  in_func    in   3   ALU op: MOV=000 ADD=001 SUB=010 AND=011 OR=100 NOT=101 NOP=110
//  in_src1    in   3   register address feeding ALU inp1
//  in_src2    in   3   register address feeding ALU inp2
//  in_dst     in   3   destination register of the result
//  in_imm_en  in   1   1: inp2 = in_imm instead of R[in_src2]
//  in_imm     in   n   immediate operand
//  out_valid  out  1   registered bundle valid toward the ALU / write-back
//  out_ready  in   1   downstream consumes the bundle
//  alu_inp1   out  n   ALU inp1 (registered)
//  alu_inp2   out  n   ALU inp2 (registered)
//  alu_func   out  3   ALU func (registered)
//  out_dst    out  3   destination address travelling with the bundle
//  wb_en      in   1   write-back strobe
//  wb_addr    in   3   write-back register address
//  wb_data    in   n   write-back data (ALU out)
// BEHAVIOUR
//  Reset: async clear of R0..R7, pending[7:0], out_valid, alu_inp1, alu_inp2, alu_func, out_dst. All clear to 0.
//  Accept: an accept occurs when in_valid && in_ready at a rising edge.
//  in_ready = (!out_valid || out_ready) && !hazard.
//  uses1 = func in {ADD,SUB,AND,OR}. MOV, NOT and NOP ignore src1.
//  uses2 = !in_imm_en && func != NOP.
//  A source is busy when pending[src]=1, unless wb_en && wb_addr==src in the same cycle (bypass).
//  hazard = (uses1 && busy(src1)) || (uses2 && busy(src2)).
//  Operand value: when wb_en && wb_addr==src, the operand takes wb_data (bypass); otherwise it takes R[src].
//  inp2 = in_imm when in_imm_en=1.
//  Unused operands still load R[src] with no stall; their value is don't-care for the ALU.
//  On accept:
//    - bundle registered; out_valid=1 in the next cycle (1-cycle latency).
//    - pending[dst] set unless func is NOP.
//  func 111 is treated as NOP: alu_func is driven as 110 and pending is not set.
//  While out_valid && !out_ready, the bundle holds stable and in_ready=0.
//  When out_valid && out_ready && no accept, out_valid falls to 0.
//  Back-to-back accepts (one per cycle) are allowed when out_ready=1 and there is no hazard.
//  Write-back: on wb_en at the edge, R[wb_addr] <= wb_data and pending[wb_addr] is cleared.
//  Write-back to a non-pending register is legal and updates the register.
//  Same-edge set and clear of the same pending bit: the set wins, and the newest issuer owns the register.
//  Arithmetic: this stage does none; all values pass unmodified at width n.
//  Mid-operation reset: everything returns to reset values immediately, including an in-flight bundle and pending bits.
// TESTING
//  T1 reset: rst_n=0 mid-transfer -> out_valid=0, alu_*=0, in_ready=1 after release, all R read as 0.
//  T2 imm issue: MOV dst=R1 imm=16'h00A5 in_imm_en=1 -> next cycle out_valid=1, alu_inp2=00A5, alu_func=000, out_dst=1, pending[1]=1.
//  T3 RAW stall: ADD R2=R1+R1 issued while pending[1]=1 -> in_ready=0 until wb_en addr=1 data=00A5.
//  T3 (cont.): in the wb cycle, in_ready=1 and alu_inp1=alu_inp2=00A5 via bypass.
//  T4 backpressure: out_ready=0 for 3 cycles with valid bundle -> alu_*/out_dst unchanged, in_ready=0.
//  T4 (cont.): release gives exactly one handoff.
//  T5 NOT ignores src1: pending[3]=1, NOT dst=R4 src1=R3 src2=R0 -> accepted with no stall, alu_func=101.
//  T6 same-edge set/clear: wb_en addr=5 and accept dst=5 on one edge -> R5=wb_data, pending[5]=1.
//  T6 (cont.): func=111 issue -> alu_func=110, pending unchanged.

Source files
------------

// File: rtl/alu_operand_fetch_if.sv
// Operand-fetch bundle interface: instruction descriptor in, ALU bundle out,
// plus the write-back port returning ALU results into the register file.
interface alu_operand_fetch_if #(
    parameter int n = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_func;
    logic [2:0]   in_src1;
    logic [2:0]   in_src2;
    logic [2:0]   in_dst;
    logic         in_imm_en;
    logic [n-1:0] in_imm;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] alu_inp1;
    logic [n-1:0] alu_inp2;
    logic [2:0]   alu_func;
    logic [2:0]   out_dst;
    logic         wb_en;
    logic [2:0]   wb_addr;
    logic [n-1:0] wb_data;

    // Upstream/downstream side: issues descriptors, consumes bundles, writes back.
    modport master (
        output in_valid, in_func, in_src1, in_src2, in_dst, in_imm_en, in_imm,
        output out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, alu_inp1, alu_inp2, alu_func, out_dst
    );

    // Stage side.
    modport slave (
        input  in_valid, in_func, in_src1, in_src2, in_dst, in_imm_en, in_imm,
        input  out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, alu_inp1, alu_inp2, alu_func, out_dst
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage in front of the 16-bit ALU: 8-entry register file,
// pending-write scoreboard with RAW stall, write-back with same-cycle bypass,
// and a registered {inp1, inp2, func, dst} bundle on a valid/ready handshake.
module alu_operand_fetch #(
    parameter int n    = 16,
    parameter int NREG = 8
) (
    input logic               clk,
    input logic               rst_n,
    alu_operand_fetch_if.slave bus
);
    typedef enum logic [2:0] {
        F_MOV = 3'b000,
        F_ADD = 3'b001,
        F_SUB = 3'b010,
        F_AND = 3'b011,
        F_OR  = 3'b100,
        F_NOT = 3'b101,
        F_NOP = 3'b110,
        F_RSV = 3'b111
    } func_e;

    logic [n-1:0]    r_regs [NREG];
    logic [NREG-1:0] r_pending;
    logic            r_out_valid;
    logic [n-1:0]    r_alu_inp1;
    logic [n-1:0]    r_alu_inp2;
    func_e           r_alu_func;
    logic [2:0]      r_out_dst;

    func_e        w_func;
    logic         w_is_nop;
    logic         w_uses1;
    logic         w_uses2;
    logic         w_byp1;
    logic         w_byp2;
    logic         w_busy1;
    logic         w_busy2;
    logic         w_hazard;
    logic         w_ready;
    logic         w_accept;
    logic [n-1:0] w_op1;
    logic [n-1:0] w_op2;

    // Decode, hazard detection and operand selection (with write-back bypass).
    always_comb begin
        w_func   = (func_e'(bus.in_func) == F_RSV) ? F_NOP : func_e'(bus.in_func);
        w_is_nop = (w_func == F_NOP);
        w_uses1  = w_func inside {F_ADD, F_SUB, F_AND, F_OR};
        w_uses2  = !bus.in_imm_en && !w_is_nop;
        w_byp1   = bus.wb_en && (bus.wb_addr == bus.in_src1);
        w_byp2   = bus.wb_en && (bus.wb_addr == bus.in_src2);
        w_busy1  = r_pending[bus.in_src1] && !w_byp1;
        w_busy2  = r_pending[bus.in_src2] && !w_byp2;
        w_hazard = (w_uses1 && w_busy1) || (w_uses2 && w_busy2);
        w_ready  = (!r_out_valid || bus.out_ready) && !w_hazard;
        w_accept = bus.in_valid && w_ready;
        w_op1    = w_byp1 ? bus.wb_data : r_regs[bus.in_src1];
        w_op2    = bus.in_imm_en ? bus.in_imm
                 : (w_byp2 ? bus.wb_data : r_regs[bus.in_src2]);
    end

    // Register file write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wb_en) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard: write-back clears, issue sets; the later set wins on a
    // same-edge collision so the newest issuer owns the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            if (bus.wb_en) begin
                r_pending[bus.wb_addr] <= 1'b0;
            end
            if (w_accept && !w_is_nop) begin
                r_pending[bus.in_dst] <= 1'b1;
            end
        end
    end

    // Output bundle register: load on accept, drop valid after an idle handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_inp1  <= '0;
            r_alu_inp2  <= '0;
            r_alu_func  <= F_MOV;
            r_out_dst   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu_inp1  <= w_op1;
            r_alu_inp2  <= w_op2;
            r_alu_func  <= w_func;
            r_out_dst   <= bus.in_dst;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_inp1  = r_alu_inp1;
    assign bus.alu_inp2  = r_alu_inp2;
    assign bus.alu_func  = r_alu_func;
    assign bus.out_dst   = r_out_dst;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: directed scenarios plus a
// randomized run against an abstract register-file / scoreboard model.
module tb_alu_operand_fetch;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   handoffs;

    alu_operand_fetch_if #(.n(16)) bus ();

    alu_operand_fetch #(.n(16), .NREG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Abstract model state
    logic [15:0] m_R [8];
    logic [7:0]  m_pend;
    logic        m_ov;
    logic [15:0] m_i1, m_i2;
    logic [2:0]  m_fn, m_dst;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_R[i] = 16'h0;
        m_pend = 8'h0;
        m_ov = 1'b0;
        m_i1 = 16'h0; m_i2 = 16'h0; m_fn = 3'd0; m_dst = 3'd0;
    endtask

    function automatic logic m_busy(input logic [2:0] s);
        return m_pend[s] && !(bus.wb_en && bus.wb_addr == s);
    endfunction

    function automatic logic m_ready();
        logic [2:0] f;
        logic u1, u2;
        f  = (bus.in_func == 3'd7) ? 3'd6 : bus.in_func;
        u1 = (f >= 3'd1) && (f <= 3'd4);
        u2 = !bus.in_imm_en && (f != 3'd6);
        return (!m_ov || bus.out_ready) &&
               !((u1 && m_busy(bus.in_src1)) || (u2 && m_busy(bus.in_src2)));
    endfunction

    // One clock edge: model follows the rules, DUT handoffs are counted.
    task automatic tick();
        logic acc;
        logic [2:0] f;
        logic [15:0] v1, v2;
        acc = bus.in_valid && m_ready();
        f   = (bus.in_func == 3'd7) ? 3'd6 : bus.in_func;
        v1  = (bus.wb_en && bus.wb_addr == bus.in_src1) ? bus.wb_data : m_R[bus.in_src1];
        if (bus.in_imm_en) v2 = bus.in_imm;
        else if (bus.wb_en && bus.wb_addr == bus.in_src2) v2 = bus.wb_data;
        else v2 = m_R[bus.in_src2];
        if (bus.out_valid && bus.out_ready) handoffs++;
        @(posedge clk);
        if (bus.wb_en) begin
            m_R[bus.wb_addr] = bus.wb_data;
            m_pend[bus.wb_addr] = 1'b0;
        end
        if (acc) begin
            m_ov = 1'b1; m_i1 = v1; m_i2 = v2; m_fn = f; m_dst = bus.in_dst;
            if (f != 3'd6) m_pend[bus.in_dst] = 1'b1;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_func = 3'd6; bus.in_src1 = 3'd0; bus.in_src2 = 3'd0;
        bus.in_dst = 3'd0; bus.in_imm_en = 1'b0; bus.in_imm = 16'h0;
        bus.wb_en = 1'b0; bus.wb_addr = 3'd0; bus.wb_data = 16'h0;
    endtask

    task automatic set_insn(input logic [2:0] f, input logic [2:0] s1, input logic [2:0] s2,
                            input logic [2:0] d, input logic ie, input logic [15:0] imm);
        bus.in_valid = 1'b1; bus.in_func = f; bus.in_src1 = s1; bus.in_src2 = s2;
        bus.in_dst = d; bus.in_imm_en = ie; bus.in_imm = imm;
    endtask

    task automatic test_reset();
        // Load some state, then reset in the middle of a transfer
        bus.out_ready = 1'b1;
        set_insn(3'd0, 3'd0, 3'd0, 3'd2, 1'b1, 16'h1111);
        bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'hFFFF;
        tick();
        bus.wb_en = 1'b0;
        set_insn(3'd0, 3'd0, 3'd0, 3'd4, 1'b1, 16'h2222);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.alu_inp1 !== 16'h0) begin errors++; $display("FAIL reset_inp1: got %h expected 0000", bus.alu_inp1); end
        checks++; if (bus.alu_inp2 !== 16'h0) begin errors++; $display("FAIL reset_inp2: got %h expected 0000", bus.alu_inp2); end
        checks++; if ({bus.alu_func, bus.out_dst} !== 6'h0) begin errors++; $display("FAIL reset_func_dst: got %h/%h expected 0/0", bus.alu_func, bus.out_dst); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        // All registers read back as zero (NOP reads without side effects)
        for (int i = 0; i < 8; i++) begin
            set_insn(3'd6, 3'(i), 3'(7 - i), 3'd0, 1'b0, 16'h0);
            tick();
            checks++;
            if (bus.alu_inp1 !== 16'h0 || bus.alu_inp2 !== 16'h0) begin
                errors++; $display("FAIL reset_reg_R%0d: got %h/%h expected 0000/0000", i, bus.alu_inp1, bus.alu_inp2);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_imm_issue();
        set_insn(3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 16'h00A5);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL imm_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        idle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL imm_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.alu_inp2 !== 16'h00A5) begin errors++; $display("FAIL imm_inp2: got %h expected 00a5", bus.alu_inp2); end
        checks++; if (bus.alu_func !== 3'd0) begin errors++; $display("FAIL imm_func: got %h expected 0", bus.alu_func); end
        checks++; if (bus.out_dst !== 3'd1) begin errors++; $display("FAIL imm_dst: got %h expected 1", bus.out_dst); end
    endtask

    task automatic test_raw_stall();
        set_insn(3'd1, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_c%0d: got %b expected 0", c, bus.in_ready); end
            tick();
        end
        bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 16'h00A5;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready: got %b expected 1", bus.in_ready); end
        tick();
        idle();
        checks++; if (bus.alu_inp1 !== 16'h00A5 || bus.alu_inp2 !== 16'h00A5) begin errors++; $display("FAIL raw_bypass: got %h/%h expected 00a5/00a5", bus.alu_inp1, bus.alu_inp2); end
        checks++; if (bus.alu_func !== 3'd1 || bus.out_dst !== 3'd2 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL raw_bundle: got f=%h d=%h v=%b expected 1/2/1", bus.alu_func, bus.out_dst, bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_insn(3'd0, 3'd0, 3'd0, 3'd6, 1'b1, 16'h7777);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, bus.in_ready); end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.alu_inp1 !== 16'h00A5 || bus.alu_inp2 !== 16'h00A5 ||
                bus.alu_func !== 3'd1 || bus.out_dst !== 3'd2) begin
                errors++; $display("FAIL bp_hold_c%0d: got v=%b %h/%h f=%h d=%h expected 1 00a5/00a5 1 2",
                                   c, bus.out_valid, bus.alu_inp1, bus.alu_inp2, bus.alu_func, bus.out_dst);
            end
        end
        idle();
        bus.out_ready = 1'b1;
        handoffs = 0;
        for (int c = 0; c < 3; c++) tick();
        checks++; if (handoffs !== 1) begin errors++; $display("FAIL bp_handoffs: got %0d expected 1", handoffs); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_not_ignores_src1();
        set_insn(3'd0, 3'd0, 3'd0, 3'd3, 1'b1, 16'h3333);
        tick();
        set_insn(3'd5, 3'd3, 3'd0, 3'd4, 1'b0, 16'h0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL not_no_stall: got %b expected 1", bus.in_ready); end
        tick();
        idle();
        checks++; if (bus.alu_func !== 3'd5 || bus.out_dst !== 3'd4 || bus.alu_inp2 !== 16'h0) begin errors++; $display("FAIL not_bundle: got f=%h d=%h i2=%h expected 5/4/0000", bus.alu_func, bus.out_dst, bus.alu_inp2); end
    endtask

    task automatic test_same_edge();
        set_insn(3'd0, 3'd0, 3'd0, 3'd5, 1'b1, 16'h1234);
        tick();
        set_insn(3'd0, 3'd0, 3'd0, 3'd5, 1'b1, 16'h5555);
        bus.wb_en = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 16'hBEEF;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.wb_en = 1'b0;
        set_insn(3'd1, 3'd5, 3'd0, 3'd7, 1'b0, 16'h0);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL same_pending_kept: got %b expected 0", bus.in_ready); end
        set_insn(3'd6, 3'd5, 3'd0, 3'd0, 1'b0, 16'h0);
        #1;
        tick();
        checks++; if (bus.alu_inp1 !== 16'hBEEF) begin errors++; $display("FAIL same_reg_value: got %h expected beef", bus.alu_inp1); end
        // Reserved func 111 behaves as NOP
        set_insn(3'd7, 3'd5, 3'd5, 3'd6, 1'b0, 16'h0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL f7_ready: got %b expected 1", bus.in_ready); end
        tick();
        checks++; if (bus.alu_func !== 3'd6 || bus.alu_inp1 !== 16'hBEEF) begin errors++; $display("FAIL f7_func: got f=%h i1=%h expected 6/beef", bus.alu_func, bus.alu_inp1); end
        set_insn(3'd1, 3'd6, 3'd0, 3'd7, 1'b0, 16'h0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL f7_no_pending: got %b expected 1", bus.in_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 600; it++) begin
            if (it == 300) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                checks++; if (bus.out_valid !== 1'b0 || bus.alu_inp1 !== 16'h0) begin errors++; $display("FAIL rnd_reset: got v=%b i1=%h expected 0/0000", bus.out_valid, bus.alu_inp1); end
                idle();
                @(negedge clk);
                rst_n = 1'b1;
            end
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_func   = 3'($urandom_range(0, 7));
            bus.in_src1   = 3'($urandom_range(0, 7));
            bus.in_src2   = 3'($urandom_range(0, 7));
            bus.in_dst    = 3'($urandom_range(0, 7));
            bus.in_imm_en = ($urandom_range(0, 3) == 0);
            bus.in_imm    = 16'($urandom);
            bus.wb_en     = ($urandom_range(0, 2) == 0);
            bus.wb_addr   = 3'($urandom_range(0, 7));
            bus.wb_data   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready it%0d: got %b expected %b", it, bus.in_ready, m_ready()); end
            tick();
            checks++;
            if (bus.out_valid !== m_ov || bus.alu_inp1 !== m_i1 || bus.alu_inp2 !== m_i2 ||
                bus.alu_func !== m_fn || bus.out_dst !== m_dst) begin
                errors++; $display("FAIL rnd_bundle it%0d: got v=%b %h/%h f=%h d=%h expected v=%b %h/%h f=%h d=%h",
                                   it, bus.out_valid, bus.alu_inp1, bus.alu_inp2, bus.alu_func, bus.out_dst,
                                   m_ov, m_i1, m_i2, m_fn, m_dst);
            end
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        handoffs = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_imm_issue();
        test_raw_stall();
        test_backpressure();
        test_not_ignores_src1();
        test_same_edge();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
